inst_fetch_resp: RTL and testbench
==================================

// Module: inst_fetch_resp
// PURPOSE
//  Responder side of the PC -> instruction-memory interface in the flowCpu_mips32 pipeline.
//  Accepts pc_i/ce_i from the PC stage and fetches the word over a req/ack memory bus.
//  Returns inst_o with a one-cycle inst_valid_o, and holds the PC stage via stall_req_o.
//  Also handles branch flush, misaligned-PC exceptions and bus timeout.
// PARAMETERS
//  ADDR_W   32   instruction address width (matches InstAddrBus)
//  DATA_W   32   instruction width (matches InstBus)
//  TIMEOUT  255  cycles spent in WAIT/DROP without mem_ack_i before bus error; range 2..255
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       reset, synchronous, active-high
//  ce_i          in   1       fetch enable from PC stage (ChipEnable = 1)
//  pc_i          in   ADDR_W  fetch address
//  flush_i       in   1       branch taken; cancel current/pending fetch
//  inst_o        out  DATA_W  fetched instruction; 0 (NOP) when not valid
//  inst_valid_o  out  1       inst_o valid, single-cycle pulse
//  stall_req_o   out  1       fetch outstanding; PC stage must hold pc_i
//  exc_adel_o    out  1       pulse: pc_i[1:0] != 0 (address error on load)
//  bus_err_o     out  1       pulse: TIMEOUT expired
//  mem_req_o     out  1       bus request, held until ack
//  mem_addr_o    out  ADDR_W  bus address, stable while mem_req_o = 1
//  mem_ack_i     in   1       bus ack; mem_rdata_i valid in the same cycle
//  mem_rdata_i   in   DATA_W  bus read data
// BEHAVIOUR
//  - All outputs are registered. Reset: state IDLE; all outputs 0; timeout counter 0.
//  - IDLE: with ce_i=1, flush_i=0 and pc_i[1:0]=0, the next edge sets mem_req_o=1,
//    mem_addr_o=pc_i, stall_req_o=1 and enters WAIT.
//  - IDLE, misaligned pc_i: next cycle exc_adel_o=1, inst_valid_o=0; no bus access; stays IDLE.
//  - IDLE with flush_i=1 or ce_i=0: no request; pc_i is ignored.
//  - WAIT: mem_req_o and mem_addr_o are held until mem_ack_i.
//    On ack: next cycle inst_o=mem_rdata_i, inst_valid_o=1, mem_req_o=0, stall_req_o=0 -> IDLE.
//    Minimum latency: pc accepted at T, ack at T+1, inst_valid_o at T+2.
//  - WAIT with flush_i=1 (no ack): -> DROP. mem_req_o stays held (the bus cannot be abandoned).
//  - DROP: on ack, the data is discarded, inst_valid_o stays 0, -> IDLE.
//  - flush_i and mem_ack_i in the same WAIT cycle: the data is discarded -> IDLE.
//  - inst_valid_o is never 1 for any fetch issued before a flush.
//  - Timeout counter: cleared when entering WAIT, increments in WAIT/DROP.
//    When the count reaches TIMEOUT-1 without ack: next cycle bus_err_o=1,
//    mem_req_o=0, stall_req_o=0 -> IDLE.
//  - inst_o returns to 0 in the cycle after the valid pulse.
//  - Back-to-back fetches: a new fetch is accepted in the same IDLE cycle in which
//    inst_valid_o is high.
//  - rst asserted mid-transaction: the next edge drops mem_req_o and returns to IDLE.
//    Any late ack arriving in IDLE is ignored.
// CONFIGURATION
//  LAST_HIT_BYPASS_EN defined:
//  - A single tag/data register holds the last successfully fetched address and word, plus a valid bit.
//  - IDLE with an aligned pc_i equal to the tag and the valid bit set: next cycle inst_valid_o=1
//    with the cached word; no bus access and no stall.
//  - The valid bit is cleared on rst and on bus_err_o.
//  LAST_HIT_BYPASS_EN undefined: every fetch goes to the bus; no tag/data registers.
// STRUCTURE
//  - defines.vh (shared) gets:
//    - fetch state encodings IFS_IDLE/IFS_WAIT/IFS_DROP (2 bits);
//    - InstAddrBus, InstBus, ChipEnable (existing) and ZeroWord.
//  - One sub-module: fetch_watchdog, the TIMEOUT counter with clear/enable/expire ports.
//    Everything else lives in a single always block for the FSM and output registers.
// TESTING
//  1. pc_i=0x0000_0000, ce_i=1, ack 1 cycle after req, rdata=0x3C01_0001
//     -> mem_addr_o=0, inst_valid_o pulse at T+2 with inst_o=0x3C01_0001.
//  2. Ack delayed 5 cycles -> stall_req_o=1 for 5 cycles, mem_req_o held, single valid pulse.
//  3. flush_i in the 2nd WAIT cycle, ack 3 cycles later -> no inst_valid_o;
//     IDLE one cycle after the ack; the next fetch of 0x40 succeeds.
//  4. pc_i=0x0000_0006 -> exc_adel_o pulse, mem_req_o stays 0.
//  5. TIMEOUT=8, ack never asserted -> bus_err_o pulses 8 cycles after mem_req_o rises;
//     mem_req_o=0 afterwards.
//  6. LAST_HIT_BYPASS_EN: fetch 0x10 twice -> the second fetch gets valid at T+1
//     with no mem_req_o; rst mid-WAIT drops mem_req_o next edge.

Source files
------------

// File: rtl/inst_fetch_resp_pkg.sv
// Shared fetch-stage definitions for inst_fetch_resp: bus widths, chip-enable level,
// the NOP word and the 2-bit fetch FSM state encodings.
package inst_fetch_resp_pkg;

    localparam int INST_ADDR_BUS = 32;
    localparam int INST_BUS      = 32;

    localparam logic        CHIP_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

    localparam logic [1:0] IFS_IDLE = 2'd0;
    localparam logic [1:0] IFS_WAIT = 2'd1;
    localparam logic [1:0] IFS_DROP = 2'd2;

    function automatic logic pc_aligned(input logic [1:0] pc_low);
        return (pc_low == 2'b00);
    endfunction

endpackage

// File: rtl/inst_fetch_resp_watchdog.sv
// fetch_watchdog: counts cycles spent waiting on the memory bus and flags expiry
// when the count reaches TIMEOUT-1 while still enabled.
module fetch_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // next count: clear wins over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/inst_fetch_resp.sv
// inst_fetch_resp: responder between the PC stage and instruction memory (req/ack bus).
// Optional feature macro: LAST_HIT_BYPASS_EN (single-entry last-fetch bypass).
module inst_fetch_resp
    import inst_fetch_resp_pkg::*;
#(
    parameter int ADDR_W  = INST_ADDR_BUS,
    parameter int DATA_W  = INST_BUS,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              stall_req_o,
    output logic              exc_adel_o,
    output logic              bus_err_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;
    logic              stall_q, stall_d;
    logic              adel_q, adel_d;
    logic              berr_q, berr_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic wd_clr_s;
    logic wd_en_s;
    logic wd_expire_s;

`ifdef LAST_HIT_BYPASS_EN
    logic              hit_vld_q, hit_vld_d;
    logic [ADDR_W-1:0] hit_tag_q, hit_tag_d;
    logic [DATA_W-1:0] hit_data_q, hit_data_d;
    logic              hit_s;

    assign hit_s = hit_vld_q && (pc_i == hit_tag_q);
`endif

    assign wd_en_s = (state_q == IFS_WAIT) || (state_q == IFS_DROP);

    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (wd_clr_s),
        .en_i     (wd_en_s),
        .expire_o (wd_expire_s)
    );

    // fetch FSM and next values of every output register
    always_comb begin
        state_d  = state_q;
        inst_d   = {DATA_W{1'b0}};
        valid_d  = 1'b0;
        adel_d   = 1'b0;
        berr_d   = 1'b0;
        req_d    = req_q;
        addr_d   = addr_q;
        stall_d  = stall_q;
        wd_clr_s = 1'b0;
`ifdef LAST_HIT_BYPASS_EN
        hit_vld_d  = hit_vld_q;
        hit_tag_d  = hit_tag_q;
        hit_data_d = hit_data_q;
`endif
        case (state_q)
            IFS_IDLE: begin
                req_d   = 1'b0;
                stall_d = 1'b0;
                if ((ce_i == CHIP_ENABLE) && !flush_i) begin
                    if (!pc_aligned(pc_i[1:0])) begin
                        adel_d = 1'b1;
`ifdef LAST_HIT_BYPASS_EN
                    end else if (hit_s) begin
                        valid_d = 1'b1;
                        inst_d  = hit_data_q;
`endif
                    end else begin
                        state_d  = IFS_WAIT;
                        req_d    = 1'b1;
                        addr_d   = pc_i;
                        stall_d  = 1'b1;
                        wd_clr_s = 1'b1;
                    end
                end else begin
                    state_d = IFS_IDLE;
                end
            end
            IFS_WAIT: begin
                if (mem_ack_i) begin
                    state_d = IFS_IDLE;
                    req_d   = 1'b0;
                    stall_d = 1'b0;
                    // a flush in the ack cycle still kills the data
                    if (!flush_i) begin
                        valid_d = 1'b1;
                        inst_d  = mem_rdata_i;
`ifdef LAST_HIT_BYPASS_EN
                        hit_vld_d  = 1'b1;
                        hit_tag_d  = addr_q;
                        hit_data_d = mem_rdata_i;
`endif
                    end else begin
                        valid_d = 1'b0;
                    end
                end else if (wd_expire_s) begin
                    state_d = IFS_IDLE;
                    req_d   = 1'b0;
                    stall_d = 1'b0;
                    berr_d  = 1'b1;
`ifdef LAST_HIT_BYPASS_EN
                    hit_vld_d = 1'b0;
`endif
                end else if (flush_i) begin
                    state_d = IFS_DROP;
                end else begin
                    state_d = IFS_WAIT;
                end
            end
            IFS_DROP: begin
                // request stays up until the bus answers; the answer is thrown away
                if (mem_ack_i) begin
                    state_d = IFS_IDLE;
                    req_d   = 1'b0;
                    stall_d = 1'b0;
                end else if (wd_expire_s) begin
                    state_d = IFS_IDLE;
                    req_d   = 1'b0;
                    stall_d = 1'b0;
                    berr_d  = 1'b1;
`ifdef LAST_HIT_BYPASS_EN
                    hit_vld_d = 1'b0;
`endif
                end else begin
                    state_d = IFS_DROP;
                end
            end
            default: begin
                state_d = IFS_IDLE;
                req_d   = 1'b0;
                stall_d = 1'b0;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IFS_IDLE;
            inst_q  <= {DATA_W{1'b0}};
            valid_q <= 1'b0;
            stall_q <= 1'b0;
            adel_q  <= 1'b0;
            berr_q  <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            adel_q  <= adel_d;
            berr_q  <= berr_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

`ifdef LAST_HIT_BYPASS_EN
    // last-hit tag/data entry
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_vld_q  <= 1'b0;
            hit_tag_q  <= {ADDR_W{1'b0}};
            hit_data_q <= {DATA_W{1'b0}};
        end else begin
            hit_vld_q  <= hit_vld_d;
            hit_tag_q  <= hit_tag_d;
            hit_data_q <= hit_data_d;
        end
    end
`endif

    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;
    assign stall_req_o  = stall_q;
    assign exc_adel_o   = adel_q;
    assign bus_err_o    = berr_q;
    assign mem_req_o    = req_q;
    assign mem_addr_o   = addr_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Table-driven bench for inst_fetch_resp with a scoreboard queue of expected instructions.
module tb_inst_fetch_resp;

    localparam int K_VALID = 0;
    localparam int K_ADEL  = 1;
    localparam int K_DROP  = 2;
    localparam int K_NONE  = 3;

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic        flush_idle;
        int          delay;
        int          flush_at;
        logic [31:0] rdata;
        int          kind;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        stall_req_o;
    logic        exc_adel_o;
    logic        bus_err_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_w;
    logic        mon_en = 1'b0;
    vec_t        vecs[11];
    vec_t        v;

    inst_fetch_resp #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ce_i         (ce_i),
        .pc_i         (pc_i),
        .flush_i      (flush_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .stall_req_o  (stall_req_o),
        .exc_adel_o   (exc_adel_o),
        .bus_err_o    (bus_err_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: every valid pulse must match the oldest expected word
    always @(negedge clk) begin
        if (mon_en) begin
            if (inst_valid_o) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_valid", 32'(inst_valid_o), 32'd0);
                end else begin
                    exp_w = sb_q.pop_front();
                    chk("inst_data", inst_o, exp_w);
                end
            end else begin
                chk("inst_zero_idle", inst_o, 32'd0);
            end
        end
    end

    task automatic run_vec(input vec_t tv);
        ce_i    = tv.ce;
        pc_i    = tv.pc;
        flush_i = tv.flush_idle;
        if (tv.kind == K_VALID) sb_q.push_back(tv.rdata);
        @(negedge clk);
        ce_i    = 1'b0;
        flush_i = 1'b0;
        if (tv.kind == K_ADEL) begin
            chk("adel_pulse", 32'(exc_adel_o), 32'd1);
            chk("adel_no_req", 32'(mem_req_o), 32'd0);
            chk("adel_no_valid", 32'(inst_valid_o), 32'd0);
        end else if (tv.kind == K_NONE) begin
            chk("none_no_req", 32'(mem_req_o), 32'd0);
            chk("none_no_adel", 32'(exc_adel_o), 32'd0);
            chk("none_no_stall", 32'(stall_req_o), 32'd0);
        end else begin
            chk("req_rise", 32'(mem_req_o), 32'd1);
            chk("req_addr", mem_addr_o, tv.pc);
            chk("stall_on", 32'(stall_req_o), 32'd1);
            for (int c = 1; c < tv.delay; c++) begin
                flush_i = (c == tv.flush_at);
                @(negedge clk);
                flush_i = 1'b0;
                chk("req_held", 32'(mem_req_o), 32'd1);
                chk("addr_held", mem_addr_o, tv.pc);
                chk("stall_held", 32'(stall_req_o), 32'd1);
                chk("no_early_valid", 32'(inst_valid_o), 32'd0);
            end
            mem_ack_i   = 1'b1;
            mem_rdata_i = tv.rdata;
            flush_i     = (tv.flush_at == tv.delay);
            @(negedge clk);
            mem_ack_i   = 1'b0;
            flush_i     = 1'b0;
            mem_rdata_i = 32'hDEAD_BEEF;
            chk("valid_after_ack", 32'(inst_valid_o), (tv.kind == K_VALID) ? 32'd1 : 32'd0);
            chk("req_drop", 32'(mem_req_o), 32'd0);
            chk("stall_drop", 32'(stall_req_o), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; ce_i = 1'b0; pc_i = 32'd0; flush_i = 1'b0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'd0;

        //           pc            ce    fl_idle delay fl_at rdata          kind
        vecs[0]  = '{32'h0000_0000, 1'b1, 1'b0, 1, 0, 32'h3C01_0001, K_VALID};
        vecs[1]  = '{32'h0000_0004, 1'b1, 1'b0, 5, 0, 32'h8C22_0004, K_VALID};
        vecs[2]  = '{32'h0000_0008, 1'b1, 1'b0, 5, 2, 32'h1111_1111, K_DROP};
        vecs[3]  = '{32'h0000_0040, 1'b1, 1'b0, 1, 0, 32'h2442_0001, K_VALID};
        vecs[4]  = '{32'h0000_0006, 1'b1, 1'b0, 0, 0, 32'h0000_0000, K_ADEL};
        vecs[5]  = '{32'h0000_0020, 1'b0, 1'b0, 0, 0, 32'h0000_0000, K_NONE};
        vecs[6]  = '{32'h0000_0025, 1'b1, 1'b1, 0, 0, 32'h0000_0000, K_NONE};
        vecs[7]  = '{32'h0000_0028, 1'b1, 1'b0, 3, 3, 32'h2222_2222, K_DROP};
        vecs[8]  = '{32'h0000_002C, 1'b1, 1'b0, 2, 0, 32'hAC43_0008, K_VALID};
        vecs[9]  = '{32'h0000_0001, 1'b1, 1'b0, 0, 0, 32'h0000_0000, K_ADEL};
        vecs[10] = '{32'h0000_0030, 1'b1, 1'b0, 1, 0, 32'h1234_5678, K_VALID};

        repeat (3) @(negedge clk);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_stall", 32'(stall_req_o), 32'd0);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_adel", 32'(exc_adel_o), 32'd0);
        chk("rst_berr", 32'(bus_err_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // vectors run back to back: each starts in the cycle the previous result appears
        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i]);
        end

        // bus timeout with TIMEOUT=8
        ce_i = 1'b1; pc_i = 32'h0000_0080;
        @(negedge clk);
        ce_i = 1'b0;
        chk("to_req_rise", 32'(mem_req_o), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k < 8) begin
                chk("to_no_berr", 32'(bus_err_o), 32'd0);
                chk("to_req_held", 32'(mem_req_o), 32'd1);
            end else begin
                chk("to_berr", 32'(bus_err_o), 32'd1);
                chk("to_req_drop", 32'(mem_req_o), 32'd0);
                chk("to_stall_drop", 32'(stall_req_o), 32'd0);
            end
        end
        @(negedge clk);
        chk("to_berr_pulse", 32'(bus_err_o), 32'd0);

        // last-hit bypass: repeated fetch of 0x10
        v = '{32'h0000_0010, 1'b1, 1'b0, 1, 0, 32'h3C1D_0010, K_VALID};
        run_vec(v);
`ifdef LAST_HIT_BYPASS_EN
        ce_i = 1'b1; pc_i = 32'h0000_0010;
        sb_q.push_back(32'h3C1D_0010);
        @(negedge clk);
        ce_i = 1'b0;
        chk("hit_valid", 32'(inst_valid_o), 32'd1);
        chk("hit_no_req", 32'(mem_req_o), 32'd0);
        chk("hit_no_stall", 32'(stall_req_o), 32'd0);
`else
        run_vec(v);
`endif

        // reset mid-WAIT, then a late ack in IDLE
        ce_i = 1'b1; pc_i = 32'h0000_0050;
        @(negedge clk);
        ce_i = 1'b0;
        chk("rw_req_rise", 32'(mem_req_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rw_req_drop", 32'(mem_req_o), 32'd0);
        chk("rw_stall_drop", 32'(stall_req_o), 32'd0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_5555;
        @(negedge clk);
        mem_ack_i = 1'b0;
        chk("late_ack_no_req", 32'(mem_req_o), 32'd0);
        chk("late_ack_no_valid", 32'(inst_valid_o), 32'd0);

        // after reset the bypass entry is gone, so this fetch must use the bus
        v = '{32'h0000_0010, 1'b1, 1'b0, 2, 0, 32'h7777_0010, K_VALID};
        run_vec(v);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
